// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, S-box/Rcon tables and key-schedule FSM encoding
package aes_pkg;

    localparam int AES_NK    = 4;
    localparam int AES_NR    = 10;
    localparam int AES_WORD  = 32;
    localparam int AES_KEY_L = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Rcon byte for rounds 1..10; round 0 never needs one
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - combinational SubWord: four parallel S-box lookups on a 32-bit word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    assign out_word = {sbox(in_word[31:24]), sbox(in_word[23:16]),
                       sbox(in_word[15:8]),  sbox(in_word[7:0])};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - walks the AES-128 key schedule backwards from round NR to round 0
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_L = AES_KEY_L,
    parameter int WORD  = AES_WORD,
    parameter int NR    = AES_NR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_L-1:0] last_key,
    input  logic             out_ready,
    output logic [KEY_L-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    state_t state;
    state_t state_nxt;

    logic            accept;
    logic [WORD-1:0] w0, w1, w2, w3;
    logic [WORD-1:0] n0, n1, n2, n3;
    logic [WORD-1:0] sub_out;

    assign accept = out_valid & out_ready;

    // Undo the forward XOR chain from the LSW upward; w0 needs the recovered w3
    assign {w0, w1, w2, w3} = round_key;
    assign n3 = w3 ^ w2;
    assign n2 = w2 ^ w1;
    assign n1 = w1 ^ w0;

    aes_sub_word u_sub_word (
        .in_word  ({n3[23:0], n3[31:24]}),
        .out_word (sub_out)
    );

    assign n0 = w0 ^ sub_out ^ {rcon(round_idx), 24'h0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_EMIT;
            ST_EMIT: if (accept && round_idx == 4'd0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == ST_EMIT);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            round_key <= '0;
            round_idx <= 4'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        round_key <= last_key;
                        round_idx <= 4'(NR);
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        if (round_idx != 4'd0) begin
                            round_key <= {n0, n1, n2, n3};
                            round_idx <= round_idx - 4'd1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - self-checking bench against a forward key-expansion reference model
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] last_key;
    logic         out_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         out_valid;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_keys [11];
    logic [127:0] got [11];

    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_inv_key_schedule dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .last_key  (last_key),
        .out_ready (out_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] fwd_key(input logic [127:0] k0, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic set_exp(input logic [127:0] k0);
        for (int r = 0; r <= 10; r++) exp_keys[r] = fwd_key(k0, r);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at the negedge after start was accepted; consumes one full 11-key sequence
    task automatic run_seq(input string tag, input bit stall, input int inject_idx,
                           input logic [127:0] inject_key, input bit chain,
                           input logic [127:0] chain_key, output int cycles);
        int           accepted;
        int           stall_left;
        int           dones;
        bit           hold;
        bit           rdy;
        logic [127:0] hk;
        logic [3:0]   hi;
        accepted = 0; dones = 0; hold = 0; cycles = 0; hk = '0; hi = '0;
        stall_left = stall ? 3 : 0;
        while (accepted < 11 && cycles < 400) begin
            cycles++;
            start = 1'b0;
            if (done) dones++;
            if (hold) begin
                chk({tag, ".hold_key"}, round_key, hk);
                chk({tag, ".hold_idx"}, 128'(round_idx), 128'(hi));
                chk({tag, ".hold_valid"}, 128'(out_valid), 128'd1);
            end
            rdy = 1'b1;
            if (out_valid) begin
                if (stall && stall_left == 0 && $urandom_range(0, 3) == 0) stall_left = 3;
                rdy = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                if (inject_idx >= 0 && int'(round_idx) == inject_idx) begin
                    start = 1'b1;
                    last_key = inject_key;
                end
                if (rdy) begin
                    chk({tag, ".key"}, round_key, exp_keys[10-accepted]);
                    chk({tag, ".idx"}, 128'(round_idx), 128'(10-accepted));
                    got[10-accepted] = round_key;
                    accepted++;
                end
                hold = !rdy;
                hk = round_key;
                hi = round_idx;
            end else begin
                hold = 1'b0;
            end
            out_ready = rdy;
            @(negedge clk);
        end
        chk({tag, ".accepted"}, 128'(accepted), 128'd11);
        chk({tag, ".early_done"}, 128'(dones), 128'd0);
        chk({tag, ".done"}, 128'(done), 128'd1);
        chk({tag, ".valid_after"}, 128'(out_valid), 128'd0);
        chk({tag, ".busy_after"}, 128'(busy), 128'd0);
        out_ready = 1'b1;
        start = 1'b0;
        if (chain) begin
            start = 1'b1;
            last_key = chain_key;
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".done_pulse"}, 128'(done), 128'd0);
    endtask

    initial begin
        int           cyc;
        logic [127:0] k_a;
        logic [127:0] k_b;

        reset = 1'b1; start = 1'b0; out_ready = 1'b1; last_key = '0;
        build_sbox();
        @(negedge clk);
        @(negedge clk);
        chk("reset.key", round_key, 128'd0);
        chk("reset.idx", 128'(round_idx), 128'd0);
        chk("reset.valid", 128'(out_valid), 128'd0);
        chk("reset.busy", 128'(busy), 128'd0);
        chk("reset.done", 128'(done), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: FIPS-197 vector, always ready
        set_exp(FIPS_K0);
        start = 1'b1; last_key = FIPS_K10;
        @(negedge clk);
        start = 1'b0;
        run_seq("t1", 1'b0, -1, '0, 1'b0, '0, cyc);
        chk("t1.latency", 128'(cyc), 128'd11);
        chk("t1.k10", got[10], FIPS_K10);
        chk("t1.k9", got[9], FIPS_K9);
        chk("t1.k1", got[1], FIPS_K1);
        chk("t1.k0", got[0], FIPS_K0);

        // 2: same key with random stalls
        start = 1'b1; last_key = FIPS_K10;
        @(negedge clk);
        start = 1'b0;
        run_seq("t2", 1'b1, -1, '0, 1'b0, '0, cyc);

        // 3: random key, stray start while busy at round 5
        k_a = rand_key();
        set_exp(k_a);
        start = 1'b1; last_key = exp_keys[10];
        @(negedge clk);
        start = 1'b0;
        run_seq("t3", 1'b1, 5, rand_key(), 1'b0, '0, cyc);

        // 4: reset (with a simultaneous start) while round 6 is presented
        start = 1'b1; last_key = FIPS_K10;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30 && !(out_valid && round_idx == 4'd6); i++) @(negedge clk);
        chk("t4.reached6", 128'(round_idx), 128'd6);
        reset = 1'b1; start = 1'b1; last_key = rand_key();
        @(negedge clk);
        chk("t4.valid", 128'(out_valid), 128'd0);
        chk("t4.busy", 128'(busy), 128'd0);
        chk("t4.key", round_key, 128'd0);
        chk("t4.idx", 128'(round_idx), 128'd0);
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4.quiet", 128'({out_valid, busy}), 128'd0);
        k_a = rand_key();
        set_exp(k_a);
        start = 1'b1; last_key = exp_keys[10];
        @(negedge clk);
        start = 1'b0;
        run_seq("t4r", 1'b0, -1, '0, 1'b0, '0, cyc);

        // 5: back-to-back sequences, second start on the done cycle
        k_a = rand_key();
        k_b = rand_key();
        set_exp(k_a);
        start = 1'b1; last_key = exp_keys[10];
        @(negedge clk);
        start = 1'b0;
        run_seq("t5a", 1'b0, -1, '0, 1'b1, fwd_key(k_b, 10), cyc);
        set_exp(k_b);
        run_seq("t5b", 1'b1, -1, '0, 1'b0, '0, cyc);

        // 6: all-zero round-0 key
        set_exp(128'd0);
        start = 1'b1; last_key = ZERO_K10;
        @(negedge clk);
        start = 1'b0;
        run_seq("t6", 1'b0, -1, '0, 1'b0, '0, cyc);
        chk("t6.k10", got[10], ZERO_K10);
        chk("t6.k0", got[0], 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
